// File: rtl/qfc_pkg.sv
// Shared definitions for the queue flow controller: FSM state encoding
// and the default sizing/divider values.
package qfc_pkg;

  localparam int QFC_DEPTH    = 8;
  localparam int QFC_LEN_W    = 4;
  localparam int QFC_DIV_FAST = 10;
  localparam int QFC_DIV_SLOW = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENQ  = 2'd1,
    ST_DEQ  = 2'd2,
    ST_ACK  = 2'd3
  } qfc_state_t;

endpackage

// File: rtl/clk_div_gen.sv
// Free-running divider: counts 0..DIV-1, drives a registered square wave
// that is high for the upper half of the count, and flags the last count.
module clk_div_gen #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_clk,
  output logic o_last
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);

  // Advance the counter; the wave is computed from the next count so it
  // is high exactly while the counter sits in the upper half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_clk <= (w_cnt_nxt >= CNT_HALF);
    end
  end

  assign o_clk  = r_clk;
  assign o_last = (r_cnt == CNT_MAX);

endmodule

// File: rtl/queue_flow_ctrl.sv
// Flow controller between a deserializer, a slow byte queue and two
// dequeue consumers. Queue commands are slot-aligned to the slow clock
// so the queue samples stable levels on its rising edge mid-slot.
//
// Handshakes: des_ready is a level "byte available"; the controller
// enqueues it for one slot, then holds des_ack high until des_ready has
// been seen low and at least DIV_FAST cycles have passed. req_a/req_b
// are levels; a grant lasts one full slot together with q_dequeue and
// is not shortened if the request drops mid-slot.
module queue_flow_ctrl
  import qfc_pkg::*;
#(
  parameter int DEPTH    = QFC_DEPTH,
  parameter int LEN_W    = QFC_LEN_W,
  parameter int DIV_FAST = QFC_DIV_FAST,
  parameter int DIV_SLOW = QFC_DIV_SLOW
) (
  input  logic             clock_1MHz,
  input  logic             rst,
  output logic             clk_100KHz,
  output logic             clk_10KHz,
  input  logic             des_ready,
  output logic             des_ack,
  input  logic [LEN_W-1:0] q_len,
  output logic             q_enqueue,
  output logic             q_dequeue,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             len_err,
  output qfc_state_t       o_dbg_state
);

  localparam int AW = (DIV_FAST > 2) ? $clog2(DIV_FAST) : 1;
  localparam logic [AW-1:0]    ACK_MIN = AW'(DIV_FAST - 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic             w_fast_unused;
  logic             w_slot_end;
  logic [1:0]       r_des_s;
  logic [1:0]       r_req_a_s;
  logic [1:0]       r_req_b_s;
  qfc_state_t       r_state;
  logic             r_enq;
  logic             r_deq;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_ack;
  logic             r_len_err;
  logic             r_ptr_b;
  logic [LEN_W-1:0] r_len_cap;
  logic [AW-1:0]    r_ack_cnt;
  logic             w_has_room;
  logic             w_not_empty;
  logic             w_any_req;
  logic             w_pick_b;

  clk_div_gen #(.DIV(DIV_FAST)) u_div_fast (
    .i_clk  (clock_1MHz),
    .i_rst  (rst),
    .o_clk  (clk_100KHz),
    .o_last (w_fast_unused)
  );

  clk_div_gen #(.DIV(DIV_SLOW)) u_div_slow (
    .i_clk  (clock_1MHz),
    .i_rst  (rst),
    .o_clk  (clk_10KHz),
    .o_last (w_slot_end)
  );

  // Two-flop synchronizers for the asynchronous request/ready levels.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      r_des_s   <= '0;
      r_req_a_s <= '0;
      r_req_b_s <= '0;
    end else begin
      r_des_s   <= {r_des_s[0], des_ready};
      r_req_a_s <= {r_req_a_s[0], req_a};
      r_req_b_s <= {r_req_b_s[0], req_b};
    end
  end

  assign w_has_room  = (q_len < DEPTH_L);
  assign w_not_empty = (q_len != '0);
  assign w_any_req   = r_req_a_s[1] | r_req_b_s[1];
  // B wins when it is the only requester or when both ask and it is B's turn.
  assign w_pick_b    = r_req_b_s[1] & (~r_req_a_s[1] | r_ptr_b);

  // Control FSM: decisions at slot boundaries, ACK exit at any cycle.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_enq     <= 1'b0;
      r_deq     <= 1'b0;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_ack     <= 1'b0;
      r_len_err <= 1'b0;
      r_ptr_b   <= 1'b0;
      r_len_cap <= '0;
      r_ack_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_slot_end) begin
            if (r_des_s[1] && w_has_room) begin
              r_state   <= ST_ENQ;
              r_enq     <= 1'b1;
              r_len_cap <= q_len;
            end else if (w_any_req && w_not_empty) begin
              r_state <= ST_DEQ;
              r_deq   <= 1'b1;
              if (w_pick_b) begin
                r_gnt_b <= 1'b1;
                r_ptr_b <= 1'b0;
              end else begin
                r_gnt_a <= 1'b1;
                r_ptr_b <= 1'b1;
              end
            end
          end
        end
        ST_ENQ: begin
          if (w_slot_end) begin
            r_enq     <= 1'b0;
            r_ack     <= 1'b1;
            r_ack_cnt <= '0;
            r_state   <= ST_ACK;
            if (q_len != r_len_cap + LEN_W'(1)) r_len_err <= 1'b1;
          end
        end
        ST_ACK: begin
          if (r_ack_cnt != ACK_MIN) begin
            r_ack_cnt <= r_ack_cnt + AW'(1);
          end else if (!r_des_s[1]) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DEQ: begin
          if (w_slot_end) begin
            r_deq   <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q_enqueue   = r_enq;
  assign q_dequeue   = r_deq;
  assign gnt_a       = r_gnt_a;
  assign gnt_b       = r_gnt_b;
  assign des_ack     = r_ack;
  assign len_err     = r_len_err;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_queue_flow_ctrl.sv
// Directed bench for queue_flow_ctrl with default parameters.
module tb_queue_flow_ctrl;
  import qfc_pkg::*;

  logic       clock_1MHz = 1'b0;
  logic       rst = 1'b1;
  logic       des_ready = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       clk_100KHz, clk_10KHz, des_ack, q_enqueue, q_dequeue;
  logic       gnt_a, gnt_b, busy, len_err;
  qfc_state_t dbg_state;
  logic [3:0] q_len;
  int         q_base = 0;
  int         q_inc = 0;
  logic       model_en = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  wire  [8:0] w_outs = {clk_100KHz, clk_10KHz, des_ack, q_enqueue, q_dequeue,
                        gnt_a, gnt_b, busy, len_err};

  queue_flow_ctrl dut (
    .clock_1MHz  (clock_1MHz),
    .rst         (rst),
    .clk_100KHz  (clk_100KHz),
    .clk_10KHz   (clk_10KHz),
    .des_ready   (des_ready),
    .des_ack     (des_ack),
    .q_len       (q_len),
    .q_enqueue   (q_enqueue),
    .q_dequeue   (q_dequeue),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .busy        (busy),
    .len_err     (len_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset-aligned cycle counter
  always #5 clock_1MHz = ~clock_1MHz;

  always @(posedge clock_1MHz or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // queue occupancy model: moves on the slow clock rising edge
  always @(posedge clk_10KHz or negedge model_en) begin
    if (!model_en)      q_inc <= 0;
    else if (q_enqueue) q_inc <= q_inc + 1;
    else if (q_dequeue) q_inc <= q_inc - 1;
  end

  assign q_len = 4'(q_base + q_inc);

  task automatic wait_cs(input int t);
    int guard;
    guard = 0;
    @(negedge clock_1MHz);
    while ((cyc % 100) != t && guard < 300) begin
      @(negedge clock_1MHz);
      guard++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clock_1MHz);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int ph_err, f_hi, f_rise, s_hi, s_rise, cmd_hi;
    logic pf, ps;
    ph_err = 0; f_hi = 0; f_rise = 0; s_hi = 0; s_rise = 0; cmd_hi = 0;
    pf = 1'b0; ps = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clock_1MHz);
    n_cmp++;
    if (w_outs !== 9'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want %b", w_outs, 9'b0);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock_1MHz);
      if (clk_100KHz !== ((cyc % 10) >= 5)) ph_err++;
      if (clk_10KHz !== ((cyc % 100) >= 50)) ph_err++;
      if (clk_100KHz) f_hi++;
      if (clk_10KHz) s_hi++;
      if (clk_100KHz && !pf) f_rise++;
      if (clk_10KHz && !ps) s_rise++;
      if (q_enqueue || q_dequeue || gnt_a || gnt_b || des_ack || busy) cmd_hi++;
      pf = clk_100KHz;
      ps = clk_10KHz;
    end
    n_cmp++;
    if (ph_err !== 0) begin n_bad++; $display("FAIL clk_phase: got %0d errors want 0", ph_err); end
    n_cmp++;
    if (f_hi !== 500) begin n_bad++; $display("FAIL fast_high: got %0d want 500", f_hi); end
    n_cmp++;
    if (f_rise !== 100) begin n_bad++; $display("FAIL fast_rises: got %0d want 100", f_rise); end
    n_cmp++;
    if (s_hi !== 500) begin n_bad++; $display("FAIL slow_high: got %0d want 500", s_hi); end
    n_cmp++;
    if (s_rise !== 10) begin n_bad++; $display("FAIL slow_rises: got %0d want 10", s_rise); end
    n_cmp++;
    if (cmd_hi !== 0) begin n_bad++; $display("FAIL idle_cmds: got %0d active cycles want 0", cmd_hi); end
  endtask

  task automatic test_enq();
    int enq_cnt;
    model_en = 1'b0;
    q_base = 3;
    model_en = 1'b1;
    des_ready = 1'b1;
    wait_cs(98);
    n_cmp++;
    if ({q_enqueue, busy} !== 2'b00) begin
      n_bad++; $display("FAIL enq_early: got %b want 00", {q_enqueue, busy});
    end
    wait_cs(0);
    n_cmp++;
    if ({q_enqueue, busy, des_ack} !== 3'b110 || dbg_state !== ST_ENQ) begin
      n_bad++; $display("FAIL enq_start: got %b/%0d want 110/%0d", {q_enqueue, busy, des_ack}, dbg_state, ST_ENQ);
    end
    enq_cnt = 1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clock_1MHz);
      if (q_enqueue) enq_cnt++;
    end
    @(negedge clock_1MHz);
    n_cmp++;
    if (enq_cnt !== 100) begin n_bad++; $display("FAIL enq_len: got %0d want 100", enq_cnt); end
    n_cmp++;
    if ({q_enqueue, des_ack, len_err} !== 3'b010 || dbg_state !== ST_ACK) begin
      n_bad++; $display("FAIL ack_entry: got %b/%0d want 010/%0d", {q_enqueue, des_ack, len_err}, dbg_state, ST_ACK);
    end
    repeat (20) @(negedge clock_1MHz);
    n_cmp++;
    if (des_ack !== 1'b1) begin n_bad++; $display("FAIL ack_hold: got %b want 1", des_ack); end
    des_ready = 1'b0;
    repeat (2) @(negedge clock_1MHz);
    n_cmp++;
    if (des_ack !== 1'b1) begin n_bad++; $display("FAIL ack_sync_delay: got %b want 1", des_ack); end
    @(negedge clock_1MHz);
    n_cmp++;
    if ({des_ack, busy, len_err} !== 3'b000) begin
      n_bad++; $display("FAIL ack_release: got %b want 000", {des_ack, busy, len_err});
    end
    wait_cs(0);
    n_cmp++;
    if ({q_enqueue, busy} !== 2'b00) begin
      n_bad++; $display("FAIL enq_no_repeat: got %b want 00", {q_enqueue, busy});
    end
  endtask

  task automatic test_len_err();
    model_en = 1'b0;
    q_base = 3;
    des_ready = 1'b1;
    wait_cs(0);
    n_cmp++;
    if (q_enqueue !== 1'b1) begin n_bad++; $display("FAIL lerr_enq: got %b want 1", q_enqueue); end
    wait_cs(99);
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL lerr_early: got %b want 0", len_err); end
    wait_cs(0);
    n_cmp++;
    if ({des_ack, len_err} !== 2'b11) begin
      n_bad++; $display("FAIL lerr_set: got %b want 11", {des_ack, len_err});
    end
    des_ready = 1'b0;
    repeat (200) @(negedge clock_1MHz);
    n_cmp++;
    if ({len_err, des_ack, busy} !== 3'b100) begin
      n_bad++; $display("FAIL lerr_sticky: got %b want 100", {len_err, des_ack, busy});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (w_outs !== 9'b0) begin n_bad++; $display("FAIL lerr_rst_clear: got %b want %b", w_outs, 9'b0); end
    @(negedge clock_1MHz);
    rst = 1'b0;
  endtask

  task automatic test_full();
    int deq_cnt, ack_cnt;
    q_base = 8;
    des_ready = 1'b1;
    req_a = 1'b1;
    wait_cs(98);
    n_cmp++;
    if ({q_enqueue, q_dequeue} !== 2'b00) begin
      n_bad++; $display("FAIL full_early: got %b want 00", {q_enqueue, q_dequeue});
    end
    wait_cs(0);
    n_cmp++;
    if ({q_enqueue, q_dequeue, gnt_a, gnt_b, des_ack} !== 5'b01100) begin
      n_bad++; $display("FAIL full_deq: got %b want 01100", {q_enqueue, q_dequeue, gnt_a, gnt_b, des_ack});
    end
    deq_cnt = 1; ack_cnt = 0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clock_1MHz);
      if (i == 30) req_a = 1'b0;
      if (q_dequeue && gnt_a) deq_cnt++;
      if (des_ack || q_enqueue) ack_cnt++;
    end
    @(negedge clock_1MHz);
    n_cmp++;
    if (deq_cnt !== 100) begin n_bad++; $display("FAIL full_deq_len: got %0d want 100", deq_cnt); end
    n_cmp++;
    if (ack_cnt !== 0) begin n_bad++; $display("FAIL full_no_ack: got %0d want 0", ack_cnt); end
    n_cmp++;
    if ({q_enqueue, q_dequeue, gnt_a, des_ack} !== 4'b0000) begin
      n_bad++; $display("FAIL full_end: got %b want 0000", {q_enqueue, q_dequeue, gnt_a, des_ack});
    end
    des_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_a;
    pulse_reset();
    q_base = 5;
    req_a = 1'b1;
    req_b = 1'b1;
    exp_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cs(0);
      n_cmp++;
      if ({q_dequeue, gnt_a, gnt_b} !== {1'b1, exp_a, ~exp_a}) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, {q_dequeue, gnt_a, gnt_b}, {1'b1, exp_a, ~exp_a});
      end
      wait_cs(0);
      n_cmp++;
      if ({q_dequeue, gnt_a, gnt_b} !== 3'b000) begin
        n_bad++; $display("FAIL rr_gap%0d: got %b want 000", i, {q_dequeue, gnt_a, gnt_b});
      end
      exp_a = ~exp_a;
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_empty();
    q_base = 0;
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_cs(0);
      n_cmp++;
      if ({q_dequeue, gnt_a, gnt_b, busy} !== 4'b0000) begin
        n_bad++; $display("FAIL empty_slot%0d: got %b want 0000", i, {q_dequeue, gnt_a, gnt_b, busy});
      end
    end
    q_base = 2;
    wait_cs(0);
    n_cmp++;
    if ({q_dequeue, gnt_a, gnt_b} !== 3'b110) begin
      n_bad++; $display("FAIL empty_ptr_kept: got %b want 110", {q_dequeue, gnt_a, gnt_b});
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    int act;
    pulse_reset();
    q_base = 3;
    des_ready = 1'b1;
    wait_cs(0);
    wait_cs(30);
    n_cmp++;
    if (q_enqueue !== 1'b1) begin n_bad++; $display("FAIL mid_enq: got %b want 1", q_enqueue); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (w_outs !== 9'b0 || dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL mid_rst_outputs: got %b/%0d want 0/%0d", w_outs, dbg_state, ST_IDLE);
    end
    des_ready = 1'b0;
    @(negedge clock_1MHz);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock_1MHz);
      if (des_ack || q_enqueue || busy) act++;
    end
    n_cmp++;
    if (act !== 0) begin n_bad++; $display("FAIL mid_no_replay: got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_enq();
    test_len_err();
    test_full();
    test_round_robin();
    test_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
